mp_regfile: RTL

MP_REGFILE -- requirements
Module: mp_regfile

---
 rtl/mp_regfile.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mp_regfile.sv
// Multi-ported architectural register file with a per-register busy
// scoreboard. Reads are combinational with optional same-cycle forwarding
// of write data; writes and scoreboard updates commit on the rising edge.
// A separate debug port always shows the committed (unforwarded) value.
module mp_regfile #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    // Committed register contents and busy bits, gathered from the
    // per-register blocks so they can be indexed by address.
    logic [XLEN-1:0] reg_q [NREG];
    logic [NREG-1:0] busy_q;

    // Unpacked views of the write ports.
    logic [AW-1:0]   waddr_a [NWR];
    logic [XLEN-1:0] wdata_a [NWR];
    logic [NWR-1:0]  wen_eff;
    logic            alloc_eff;

    // Writes and allocations aimed at a hardwired-zero register are
    // dropped here once, so neither storage, scoreboard nor forwarding
    // ever sees them.
    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wport
            assign waddr_a[gi] = waddr[gi*AW +: AW];
            assign wdata_a[gi] = wdata[gi*XLEN +: XLEN];
            assign wen_eff[gi] = wen[gi] &&
                                 !((ZERO_REG != 0) && (waddr_a[gi] == '0));
        end
    endgenerate

    assign alloc_eff = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

    // One storage word plus one busy bit per architectural register.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [XLEN-1:0] data_reg;
            logic [XLEN-1:0] data_next;
            logic            busy_reg;
            logic            busy_next;

            // Next state: ascending port scan lets the highest-index
            // writer win; alloc is applied last so it overrides the
            // clear caused by a same-cycle write.
            always_comb begin
                data_next = data_reg;
                busy_next = busy_reg;
                for (int j = 0; j < NWR; j++) begin
                    if (wen_eff[j] && (waddr_a[j] == AW'(gi))) begin
                        data_next = wdata_a[j];
                        busy_next = 1'b0;
                    end
                end
                if (alloc_eff && (alloc_addr == AW'(gi))) begin
                    busy_next = 1'b1;
                end
            end

            // State register; reset wins over any write or alloc.
            always_ff @(posedge clock) begin
                if (reset) begin
                    data_reg <= '0;
                    busy_reg <= 1'b0;
                end else begin
                    data_reg <= data_next;
                    busy_reg <= busy_next;
                end
            end

            assign reg_q[gi]  = data_reg;
            assign busy_q[gi] = busy_reg;
        end
    endgenerate

    // Read ports: stored value, optionally overridden by the highest
    // enabled writer to the same address this cycle.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rport
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd_val;
            logic            rb_val;

            assign ra = raddr[gi*AW +: AW];

            // Combinational read with forwarding and zero-register masking.
            always_comb begin
                rd_val = reg_q[ra];
                rb_val = busy_q[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wen_eff[j] && (waddr_a[j] == ra)) begin
                            rd_val = wdata_a[j];
                            rb_val = 1'b0;
                        end
                    end
                end
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd_val = '0;
                    rb_val = 1'b0;
                end
            end

            assign rdata[gi*XLEN +: XLEN] = rd_val;
            assign rbusy[gi]              = rb_val;
        end
    endgenerate

    // Debug port shows only committed state, never forwarded data.
    always_comb begin
        dbg_data = reg_q[dbg_addr];
        if ((ZERO_REG != 0) && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
    end

endmodule
